// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU load/store port to valid/ready memory bus, with lane alignment, load extension, fault and timeout
module dmem_bridge #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_load,
   input  logic              mem_store,
   input  logic [XLEN-1:0]   address,
   input  logic [XLEN-1:0]   store_data,
   input  logic [2:0]        funct3,
   output logic [XLEN-1:0]   load_data,
   output logic              stall,
   output logic              fault,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_req_we,
   output logic [XLEN-1:0]   bus_req_addr,
   output logic [XLEN-1:0]   bus_req_wdata,
   output logic [XLEN/8-1:0] bus_req_wstrb,
   input  logic              bus_rsp_valid,
   input  logic [XLEN-1:0]   bus_rsp_rdata,
   input  logic              bus_rsp_err
);
   localparam int NB = XLEN/8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT+1);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d, data_q, data_d, load_data_q, load_data_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            we_q, we_d, fault_q, fault_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      amask;
   logic [7:0]      mask8;
   logic [NB-1:0]   mask;
   logic [OW-1:0]   off;
   logic [XLEN-1:0] sh, ext;
   logic            busy, illegal, misaligned, timeout_hit;
   assign busy        = state_q == REQ || state_q == WAIT;
   assign timeout_hit = busy && cnt_q == CW'(TIMEOUT-1);
   assign amask       = funct3[1:0] == 2'd0 ? 3'd0 : funct3[1:0] == 2'd1 ? 3'd1 : funct3[1:0] == 2'd2 ? 3'd3 : 3'd7;
   assign misaligned  = |(address[2:0] & amask);
   assign illegal     = funct3[1:0] == 2'b11 && (funct3[2] || XLEN == 32);
   assign off         = addr_q[OW-1:0];
   assign mask8       = funct3_q[1:0] == 2'd0 ? 8'h01 : funct3_q[1:0] == 2'd1 ? 8'h03 : funct3_q[1:0] == 2'd2 ? 8'h0F : 8'hFF;
   assign mask        = mask8[NB-1:0];
   assign sh          = bus_rsp_rdata >> {off, 3'b000};
   assign ext = funct3_q == 3'b000 ? XLEN'($signed(sh[7:0]))  :
                funct3_q == 3'b001 ? XLEN'($signed(sh[15:0])) :
                funct3_q == 3'b010 ? XLEN'($signed(sh[31:0])) :
                funct3_q == 3'b100 ? XLEN'(sh[7:0])           :
                funct3_q == 3'b101 ? XLEN'(sh[15:0])          :
                funct3_q == 3'b110 ? XLEN'(sh[31:0])          : sh;
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      funct3_d    = funct3_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
      fault_d     = 1'b0;
      if (state_q == IDLE && (mem_load || mem_store)) begin
         if ((mem_load && mem_store) || illegal || misaligned) begin
            state_d = DONE;
            fault_d = 1'b1;
            if (mem_load) load_data_d = '0;
         end else begin
            state_d  = REQ;
            addr_d   = address;
            data_d   = store_data;
            funct3_d = funct3;
            we_d     = mem_store;
            cnt_d    = '0;
         end
      end else if (busy) begin
         cnt_d = cnt_q + 1'b1;
         // a response landing on the last allowed cycle still completes normally
         if (state_q == WAIT && bus_rsp_valid) begin
            state_d = DONE;
            fault_d = bus_rsp_err;
            if (!we_q) load_data_d = bus_rsp_err ? '0 : ext;
         end else if (timeout_hit) begin
            state_d = DONE;
            fault_d = 1'b1;
            if (!we_q) load_data_d = '0;
         end else if (state_q == REQ && bus_req_ready) state_d = WAIT;
      end else if (state_q == DONE) state_d = IDLE;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         funct3_q    <= '0;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         load_data_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         funct3_q    <= funct3_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
      end
   end
   assign load_data     = load_data_q;
   assign fault         = reset && fault_q;
   assign stall         = reset && ((state_q == IDLE && (mem_load || mem_store)) || busy);
   assign bus_req_valid = reset && state_q == REQ && !timeout_hit;
   assign bus_req_we    = we_q;
   assign bus_req_addr  = {addr_q[XLEN-1:OW], {OW{1'b0}}};
   assign bus_req_wdata = data_q << {off, 3'b000};
   assign bus_req_wstrb = we_q ? mask << off : '0;
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scenarios for dmem_bridge with hand-computed expectations
module tb_dmem_bridge;
   logic        clock = 1'b0;
   logic        reset, mem_load, mem_store;
   logic [63:0] address, store_data, load_data;
   logic [2:0]  funct3;
   logic        stall, fault;
   logic        bus_req_valid, bus_req_ready, bus_req_we;
   logic [63:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
   logic [7:0]  bus_req_wstrb;
   logic        bus_rsp_valid, bus_rsp_err;
   int checks = 0, errors = 0;
   always #5 clock = ~clock;
   dmem_bridge #(.XLEN(64), .TIMEOUT(255)) dut (
      .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
      .address(address), .store_data(store_data), .funct3(funct3),
      .load_data(load_data), .stall(stall), .fault(fault),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
   );
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   // zero-wait-state load: ends one time unit into the DONE cycle with the CPU request dropped
   task automatic do_load(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] rd, input logic err);
      mem_load = 1; address = a; funct3 = f3; bus_req_ready = 1;
      step;
      step;
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = rd; bus_rsp_err = err;
      step;
      mem_load = 0; bus_rsp_valid = 0; bus_rsp_err = 0;
   endtask
   task automatic test_reset;
      reset = 0; mem_load = 1; mem_store = 0; address = 64'h1000; store_data = 0; funct3 = 3'b011;
      bus_req_ready = 1; bus_rsp_valid = 0; bus_rsp_rdata = 0; bus_rsp_err = 0;
      step;
      step;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
      checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_req_valid); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
      checks++; if (load_data !== 64'h0) begin errors++; $display("FAIL reset_load_data got %h want 0", load_data); end
      mem_load = 0; bus_req_ready = 0; reset = 1;
      step;
   endtask
   task automatic test_lb;
      address = 64'h1003; funct3 = 3'b000; mem_load = 1; bus_req_ready = 1;
      #1;
      checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL lb_idle stall=%b valid=%b want 1 0", stall, bus_req_valid); end
      step;
      checks++; if (bus_req_valid !== 1'b1 || stall !== 1'b1 || bus_req_addr !== 64'h1000 || bus_req_we !== 1'b0 || bus_req_wstrb !== 8'h00)
         begin errors++; $display("FAIL lb_req valid=%b stall=%b addr=%h we=%b strb=%h want 1 1 1000 0 00", bus_req_valid, stall, bus_req_addr, bus_req_we, bus_req_wstrb); end
      step;
      bus_rsp_valid = 1; bus_rsp_rdata = 64'h0000_0000_80FF_0000;
      #1;
      checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL lb_wait stall=%b valid=%b want 1 0", stall, bus_req_valid); end
      step;
      mem_load = 0; bus_rsp_valid = 0; bus_req_ready = 0;
      checks++; if (stall !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL lb_done stall=%b fault=%b want 0 0", stall, fault); end
      checks++; if (load_data !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffffffffffff80", load_data); end
      step;
      checks++; if (load_data !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_hold got %h want ffffffffffffff80", load_data); end
   endtask
   task automatic test_sh;
      mem_store = 1; address = 64'h1006; store_data = 64'h1234; funct3 = 3'b001; bus_req_ready = 0;
      step;
      address = 64'h0; store_data = '1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus_req_valid !== 1'b1 || bus_req_we !== 1'b1 || bus_req_addr !== 64'h1000 || bus_req_wdata !== 64'h1234_0000_0000_0000 || bus_req_wstrb !== 8'hC0)
            begin errors++; $display("FAIL sh_hold%0d valid=%b we=%b addr=%h wdata=%h strb=%h want 1 1 1000 1234000000000000 c0", i, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb); end
         if (i == 2) bus_req_ready = 1;
         step;
      end
      bus_req_ready = 0;
      checks++; if (bus_req_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL sh_wait valid=%b stall=%b want 0 1", bus_req_valid, stall); end
      bus_rsp_valid = 1; bus_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      step;
      mem_store = 0; bus_rsp_valid = 0;
      checks++; if (fault !== 1'b0 || stall !== 1'b0 || load_data !== 64'hFFFF_FFFF_FFFF_FF80)
         begin errors++; $display("FAIL sh_done fault=%b stall=%b data=%h want 0 0 ffffffffffffff80", fault, stall, load_data); end
      step;
   endtask
   task automatic test_lwu;
      mem_load = 1; address = 64'h1004; funct3 = 3'b110; bus_req_ready = 0;
      bus_rsp_valid = 1; bus_rsp_err = 1; bus_rsp_rdata = '1;
      step;
      step;
      checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b1 || fault !== 1'b0)
         begin errors++; $display("FAIL lwu_early_rsp stall=%b valid=%b fault=%b want 1 1 0", stall, bus_req_valid, fault); end
      bus_req_ready = 1; bus_rsp_valid = 0; bus_rsp_err = 0;
      step;
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 64'h8765_4321_DEAD_BEEF;
      step;
      mem_load = 0; bus_rsp_valid = 0;
      checks++; if (load_data !== 64'h0000_0000_8765_4321 || fault !== 1'b0)
         begin errors++; $display("FAIL lwu_data got %h fault=%b want 0000000087654321 0", load_data, fault); end
      step;
   endtask
   task automatic test_misaligned;
      mem_load = 1; address = 64'h1002; funct3 = 3'b010;
      #1;
      checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL mis_idle stall=%b valid=%b want 1 0", stall, bus_req_valid); end
      step;
      mem_load = 0;
      checks++; if (fault !== 1'b1 || bus_req_valid !== 1'b0 || stall !== 1'b0 || load_data !== 64'h0)
         begin errors++; $display("FAIL mis_done fault=%b valid=%b stall=%b data=%h want 1 0 0 0", fault, bus_req_valid, stall, load_data); end
      step;
      checks++; if (fault !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse fault=%b valid=%b want 0 0", fault, bus_req_valid); end
   endtask
   task automatic test_both;
      mem_load = 1; mem_store = 1; address = 64'h1000; funct3 = 3'b011;
      #1;
      checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL both_idle valid=%b want 0", bus_req_valid); end
      step;
      mem_load = 0; mem_store = 0;
      checks++; if (fault !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL both_done fault=%b valid=%b want 1 0", fault, bus_req_valid); end
      step;
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL both_pulse fault=%b want 0", fault); end
   endtask
   task automatic test_lh;
      do_load(64'h100A, 3'b001, 64'h0000_0000_9ABC_0000, 1'b0);
      checks++; if (load_data !== 64'hFFFF_FFFF_FFFF_9ABC || fault !== 1'b0)
         begin errors++; $display("FAIL lh_data got %h fault=%b want ffffffffffff9abc 0", load_data, fault); end
      step;
   endtask
   task automatic test_timeout;
      int n;
      mem_load = 1; address = 64'h1020; funct3 = 3'b011; bus_req_ready = 1;
      step;
      n = 0;
      while (stall === 1'b1 && n < 400) begin
         n++;
         step;
      end
      mem_load = 0; bus_req_ready = 0;
      checks++; if (n !== 255) begin errors++; $display("FAIL timeout_cycles got %0d want 255", n); end
      checks++; if (fault !== 1'b1 || load_data !== 64'h0 || bus_req_valid !== 1'b0)
         begin errors++; $display("FAIL timeout_done fault=%b data=%h valid=%b want 1 0 0", fault, load_data, bus_req_valid); end
      step;
      checks++; if (fault !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL timeout_after fault=%b stall=%b want 0 0", fault, stall); end
   endtask
   task automatic test_lbu_err_ld;
      do_load(64'h1001, 3'b100, 64'h0000_0000_0000_8000, 1'b0);
      checks++; if (load_data !== 64'h80) begin errors++; $display("FAIL lbu_data got %h want 80", load_data); end
      step;
      do_load(64'h1008, 3'b011, 64'h1111_2222_3333_4444, 1'b1);
      checks++; if (fault !== 1'b1 || load_data !== 64'h0) begin errors++; $display("FAIL err_done fault=%b data=%h want 1 0", fault, load_data); end
      step;
      do_load(64'h1010, 3'b011, 64'h0123_4567_89AB_CDEF, 1'b0);
      checks++; if (fault !== 1'b0 || load_data !== 64'h0123_4567_89AB_CDEF)
         begin errors++; $display("FAIL ld_data fault=%b data=%h want 0 0123456789abcdef", fault, load_data); end
      step;
   endtask
   task automatic test_reset_mid;
      mem_load = 1; address = 64'h1018; funct3 = 3'b011; bus_req_ready = 1;
      step;
      step;
      checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_wait stall=%b valid=%b want 1 0", stall, bus_req_valid); end
      reset = 0; mem_load = 0; bus_req_ready = 0;
      step;
      checks++; if (stall !== 1'b0 || bus_req_valid !== 1'b0 || fault !== 1'b0 || load_data !== 64'h0)
         begin errors++; $display("FAIL rmid_reset stall=%b valid=%b fault=%b data=%h want 0 0 0 0", stall, bus_req_valid, fault, load_data); end
      reset = 1; bus_rsp_valid = 1; bus_rsp_rdata = '1;
      step;
      bus_rsp_valid = 0;
      checks++; if (fault !== 1'b0 || load_data !== 64'h0 || stall !== 1'b0)
         begin errors++; $display("FAIL rmid_late_rsp fault=%b data=%h stall=%b want 0 0 0", fault, load_data, stall); end
      step;
   endtask
   initial begin
      test_reset;
      test_lb;
      test_sh;
      test_lwu;
      test_misaligned;
      test_both;
      test_lh;
      test_timeout;
      test_lbu_err_ld;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
